vrf_read_port_arbiter: RTL and testbench
========================================

Name: vrf_read_port_arbiter

Overview:
- Shares the limited read ports of the lane vector register file among several operand requesters: ALU operand fetch, store data path, index/mask unit.
- Each requester asks for a burst of consecutive register-file entries.
- The block assigns the burst to a free read port in round-robin order, drives that port's read address each cycle, and routes the register file's 1-cycle-late read data back to the owning requester with valid/last flags.

Parameters:
- REQ_NUM, 4, number of requesters.
- PORT_NUM, 2, number of register-file read ports managed.
- DATA_W, 32, register-file entry width.
- RF_DEPTH, 32, register-file entries; ADDR_W = $clog2(RF_DEPTH).
- LEN_W, 4, burst length field width; burst length = req_len_i + 1 (1..16).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous abort of all bursts and in-flight responses.
- req_valid_i  in  REQ_NUM  burst request pending, per requester.
- req_addr_i  in  REQ_NUM x ADDR_W  burst start entry.
- req_len_i  in  REQ_NUM x LEN_W  burst length minus one.
- req_ready_o  out  REQ_NUM  request accepted this cycle (combinational grant).
- rf_read_addr_o  out  PORT_NUM x ADDR_W  read address to register file port.
- rf_read_data_i  in  PORT_NUM x DATA_W  register-file read data; valid one cycle after address.
- rsp_valid_o  out  REQ_NUM  response data valid.
- rsp_last_o  out  REQ_NUM  final element of burst.
- rsp_data_o  out  REQ_NUM x DATA_W  routed read data.
- busy_o  out  1  any port busy or any response in flight.

Behaviour:
- **Reset (rst_i=1, async):** all ports IDLE, owners/counters/addresses 0, round-robin pointer 0, response pipeline cleared. All outputs 0.
  - A reset mid-burst discards the burst. Requesters must re-request.
- **Per-port FSM:** IDLE -> BUSY on accept. BUSY -> IDLE on the cycle after the last address is issued.
  - A port is never re-granted in the cycle its last read issues, so there is one bubble between bursts on the same port.
- **Accept:**
  - Each cycle, free (IDLE) ports are filled in ascending port index.
  - Each free port takes the next pending requester, searching round-robin from rr_ptr.
  - A requester already owning a port is skipped.
  - req_ready_o[r]=1 only in the grant cycle. Handshake = req_valid_i & req_ready_o.
  - req_valid_i must stay high with stable addr/len until ready.
- **rr_ptr:** after any grant, advances to (last granted requester + 1) mod REQ_NUM.
- **Issue:**
  - A burst accepted at edge N issues addresses addr, addr+1, …, one per cycle, on cycles N+1 .. N+len+1.
  - Addresses wrap modulo RF_DEPTH (31 -> 0).
  - rf_read_addr_o holds 0 while IDLE.
- **Response:**
  - Owner id, port id and last flag are registered on each issue cycle.
  - On the next cycle: rsp_valid_o[owner]=1, rsp_data_o[owner]=rf_read_data_i[port], rsp_last_o[owner]=1 on the final element.
  - Response latency = 2 cycles from accept edge to first data. There is no response backpressure.
  - rsp_data_o is 0 when rsp_valid_o=0.
- **flush_i:**
  - Takes priority over accept/issue.
  - Next edge: all ports IDLE, response pipeline cleared. rr_ptr is kept.
  - req_ready_o is forced 0 while flush_i=1.
- **Simultaneous events:** more requesters than free ports means the excess wait. A requester's rsp_valid_o never asserts from two ports in the same cycle, because a requester owns at most one port.
- **busy_o:** asserted while any port is BUSY or any response is pending.

Test Plan:
- **Single burst:** reset, then req0 valid addr=5 len=2 at cycle 1.
  - Expect req_ready_o[0]=1 at cycle 1.
  - Port0 addresses 5,6,7 on cycles 2–4.
  - rsp_valid_o[0] on cycles 3–5 with data = RF[5..7], rsp_last_o[0] only at cycle 5.
- **Wrap:** req1 addr=30 len=3 -> addresses 30,31,0,1; four responses, last on the 4th.
- **Contention, REQ_NUM=4, PORT_NUM=2:** req0..req3 all valid len=0 at the same cycle.
  - Grants {0,1} first (port0=req0, port1=req1), then {2,3} two cycles later, then rr_ptr=0.
  - A re-raised req0 is granted only after req2/req3.
- **Back-to-back:** req0 len=0 repeated continuously on one port -> grants every 2 cycles (one bubble).
- **flush:** flush_i pulsed mid-burst (req0 addr=0 len=7, flush after 3rd address).
  - No further addresses or rsp_valid_o after the flush edge; busy_o=0.
  - A new request is accepted the cycle after flush deasserts.
- **Async reset:** rst_i asserted mid-burst between clock edges -> all outputs 0 immediately without a clock edge; no responses after release until a new accept.

Source files
------------

// File: rtl/vrf_read_port_arbiter.sv
// Round-robin allocation of VRF read ports to burst requesters; each port
// walks its burst one address per cycle and the 1-cycle-late data is routed back.
module vrf_read_port_arbiter #(
  parameter int  REQ_NUM  = 4,
  parameter int  PORT_NUM = 2,
  parameter int  DATA_W   = 32,
  parameter int  RF_DEPTH = 32,
  parameter int  LEN_W    = 4,
  localparam int ADDR_W   = $clog2(RF_DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [REQ_NUM-1:0]           req_valid_i,
  input  logic [REQ_NUM*ADDR_W-1:0]    req_addr_i,
  input  logic [REQ_NUM*LEN_W-1:0]     req_len_i,
  output logic [REQ_NUM-1:0]           req_ready_o,
  output logic [PORT_NUM*ADDR_W-1:0]   rf_read_addr_o,
  input  logic [PORT_NUM*DATA_W-1:0]   rf_read_data_i,
  output logic [REQ_NUM-1:0]           rsp_valid_o,
  output logic [REQ_NUM-1:0]           rsp_last_o,
  output logic [REQ_NUM*DATA_W-1:0]    rsp_data_o,
  output logic                         busy_o
);

  localparam int REQ_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic { IDLE, BUSY } state_e;

  state_e            state_q [PORT_NUM];
  state_e            state_d [PORT_NUM];
  logic [ADDR_W-1:0] addr_q  [PORT_NUM];
  logic [ADDR_W-1:0] addr_d  [PORT_NUM];
  logic [LEN_W-1:0]  left_q  [PORT_NUM];
  logic [LEN_W-1:0]  left_d  [PORT_NUM];
  logic [REQ_W-1:0]  owner_q [PORT_NUM];
  logic [REQ_W-1:0]  owner_d [PORT_NUM];
  logic              pv_q    [PORT_NUM];
  logic              pv_d    [PORT_NUM];
  logic              plast_q [PORT_NUM];
  logic              plast_d [PORT_NUM];
  logic [REQ_W-1:0]  pown_q  [PORT_NUM];
  logic [REQ_W-1:0]  pown_d  [PORT_NUM];
  logic [REQ_W-1:0]  rr_q;
  logic [REQ_W-1:0]  rr_d;

  logic [REQ_NUM-1:0] grant;
  logic               gnt_v [PORT_NUM];
  logic [REQ_W-1:0]   gnt_r [PORT_NUM];
  logic               any_grant;
  logic [REQ_W-1:0]   last_gnt;

  // Free ports are filled in ascending order; each pick is removed from the
  // candidate set so later ports in the same cycle search past it.
  always_comb begin : grant_comb
    logic [REQ_NUM-1:0] taken;
    logic [REQ_W-1:0]   cand;
    logic               found;
    taken     = '0;
    grant     = '0;
    any_grant = 1'b0;
    last_gnt  = rr_q;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      gnt_v[p] = 1'b0;
      gnt_r[p] = '0;
      if (state_q[p] == BUSY) taken[owner_q[p]] = 1'b1;
    end
    if (!flush_i) begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        found = 1'b0;
        if (state_q[p] == IDLE) begin
          for (int unsigned k = 0; k < REQ_NUM; k++) begin
            cand = REQ_W'((32'(rr_q) + k) % 32'(REQ_NUM));
            if (!found && req_valid_i[cand] && !taken[cand]) begin
              found       = 1'b1;
              gnt_v[p]    = 1'b1;
              gnt_r[p]    = cand;
              taken[cand] = 1'b1;
              grant[cand] = 1'b1;
              last_gnt    = cand;
              any_grant   = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (any_grant)
      rr_d = (32'(last_gnt) == 32'(REQ_NUM - 1)) ? '0 : last_gnt + 1'b1;
  end

  assign req_ready_o = rst_i ? '0 : grant;

  always_comb begin
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      state_d[p] = state_q[p];
      addr_d[p]  = addr_q[p];
      left_d[p]  = left_q[p];
      owner_d[p] = owner_q[p];
      pv_d[p]    = 1'b0;
      plast_d[p] = 1'b0;
      pown_d[p]  = '0;
      if (flush_i) begin
        state_d[p] = IDLE;
        addr_d[p]  = '0;
        left_d[p]  = '0;
        owner_d[p] = '0;
      end else if (state_q[p] == IDLE) begin
        if (gnt_v[p]) begin
          state_d[p] = BUSY;
          addr_d[p]  = req_addr_i[32'(gnt_r[p])*ADDR_W +: ADDR_W];
          left_d[p]  = req_len_i[32'(gnt_r[p])*LEN_W +: LEN_W];
          owner_d[p] = gnt_r[p];
        end
      end else begin
        pv_d[p]    = 1'b1;
        plast_d[p] = (left_q[p] == '0);
        pown_d[p]  = owner_q[p];
        if (left_q[p] == '0) begin
          state_d[p] = IDLE;
          addr_d[p]  = '0;
          owner_d[p] = '0;
        end else begin
          addr_d[p] = addr_q[p] + 1'b1;
          left_d[p] = left_q[p] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= '0;
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        state_q[p] <= IDLE;
        addr_q[p]  <= '0;
        left_q[p]  <= '0;
        owner_q[p] <= '0;
        pv_q[p]    <= 1'b0;
        plast_q[p] <= 1'b0;
        pown_q[p]  <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        state_q[p] <= state_d[p];
        addr_q[p]  <= addr_d[p];
        left_q[p]  <= left_d[p];
        owner_q[p] <= owner_d[p];
        pv_q[p]    <= pv_d[p];
        plast_q[p] <= plast_d[p];
        pown_q[p]  <= pown_d[p];
      end
    end
  end

  // A requester owns at most one port, so per-requester writes never collide.
  always_comb begin
    rf_read_addr_o = '0;
    rsp_valid_o    = '0;
    rsp_last_o     = '0;
    rsp_data_o     = '0;
    busy_o         = 1'b0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      if (state_q[p] == BUSY) begin
        rf_read_addr_o[p*ADDR_W +: ADDR_W] = addr_q[p];
        busy_o = 1'b1;
      end
      if (pv_q[p]) begin
        rsp_valid_o[pown_q[p]] = 1'b1;
        rsp_last_o[pown_q[p]]  = plast_q[p];
        rsp_data_o[32'(pown_q[p])*DATA_W +: DATA_W] = rf_read_data_i[p*DATA_W +: DATA_W];
        busy_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vrf_read_port_arbiter.sv
// Bench for vrf_read_port_arbiter: directed vectors/sequences plus random
// traffic checked every cycle against a transaction-level reference model.
module tb_vrf_read_port_arbiter;

  localparam int RN = 4;
  localparam int PN = 2;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LW = 4;
  localparam int DEPTH = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic [RN-1:0]   req_valid_i = '0;
  logic [RN*AW-1:0] req_addr_i = '0;
  logic [RN*LW-1:0] req_len_i = '0;
  logic [RN-1:0]   req_ready_o;
  logic [PN*AW-1:0] rf_read_addr_o;
  logic [PN*DW-1:0] rf_read_data_i = '0;
  logic [RN-1:0]   rsp_valid_o;
  logic [RN-1:0]   rsp_last_o;
  logic [RN*DW-1:0] rsp_data_o;
  logic            busy_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rf_mem [DEPTH];

  vrf_read_port_arbiter #(
    .REQ_NUM(RN), .PORT_NUM(PN), .DATA_W(DW), .RF_DEPTH(DEPTH), .LEN_W(LW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .req_ready_o(req_ready_o), .rf_read_addr_o(rf_read_addr_o),
    .rf_read_data_i(rf_read_data_i), .rsp_valid_o(rsp_valid_o),
    .rsp_last_o(rsp_last_o), .rsp_data_o(rsp_data_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Register file: synchronous read, data valid the cycle after the address.
  always @(posedge clk_i)
    for (int p = 0; p < PN; p++)
      rf_read_data_i[p*DW +: DW] <= rf_mem[rf_read_addr_o[p*AW +: AW]];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int r, input int a, input int l);
    req_addr_i[r*AW +: AW] = AW'(a);
    req_len_i[r*LW +: LW]  = LW'(l);
    req_valid_i[r]         = 1'b1;
  endtask

  // Reference model: bursts tracked as (owner, next address, beats left);
  // responses expected the cycle after each issued address.
  int        m_rr;
  bit        m_busy [PN];
  int        m_own  [PN];
  int        m_addr [PN];
  int        m_left [PN];
  bit        m_iv   [PN];
  int        m_iown [PN];
  int        m_iaddr[PN];
  bit        m_ilast[PN];
  logic [RN-1:0] exp_ready = '0;

  always @(negedge clk_i) begin : model
    logic [RN-1:0]    e_rdy, e_vld, e_last;
    logic [RN*DW-1:0] e_data;
    logic [PN*AW-1:0] e_addr;
    logic             e_busy;
    bit               owned [RN];
    int               gown  [PN];
    int               last_g, r;
    bit               any_g;
    if (rst_i) begin
      m_rr = 0;
      for (int p = 0; p < PN; p++) begin m_busy[p] = 0; m_iv[p] = 0; end
      exp_ready = '0;
      chk("rst_ready", 128'(req_ready_o), 128'(0));
      chk("rst_addr", 128'(rf_read_addr_o), 128'(0));
      chk("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
      chk("rst_rsp_data", 128'(rsp_data_o), 128'(0));
      chk("rst_busy", 128'(busy_o), 128'(0));
    end else begin
      e_vld = '0; e_last = '0; e_data = '0; e_addr = '0; e_busy = 1'b0; e_rdy = '0;
      any_g = 0; last_g = 0;
      for (int q = 0; q < RN; q++) owned[q] = 0;
      for (int p = 0; p < PN; p++) begin
        gown[p] = -1;
        if (m_iv[p]) begin
          e_vld[m_iown[p]]  = 1'b1;
          e_last[m_iown[p]] = m_ilast[p];
          e_data[m_iown[p]*DW +: DW] = rf_mem[m_iaddr[p]];
          e_busy = 1'b1;
        end
        if (m_busy[p]) begin
          e_addr[p*AW +: AW] = AW'(m_addr[p]);
          e_busy = 1'b1;
          owned[m_own[p]] = 1;
        end
      end
      if (!flush_i) begin
        for (int p = 0; p < PN; p++) begin
          if (!m_busy[p]) begin
            for (int k = 0; k < RN; k++) begin
              r = (m_rr + k) % RN;
              if (gown[p] < 0 && req_valid_i[r] && !owned[r]) begin
                gown[p] = r; owned[r] = 1; e_rdy[r] = 1'b1; last_g = r; any_g = 1;
              end
            end
          end
        end
      end
      chk("ready", 128'(req_ready_o), 128'(e_rdy));
      chk("rf_addr", 128'(rf_read_addr_o), 128'(e_addr));
      chk("rsp_valid", 128'(rsp_valid_o), 128'(e_vld));
      chk("rsp_last", 128'(rsp_last_o), 128'(e_last));
      chk("rsp_data", 128'(rsp_data_o), 128'(e_data));
      chk("busy", 128'(busy_o), 128'(e_busy));
      exp_ready = e_rdy;
      if (flush_i) begin
        for (int p = 0; p < PN; p++) begin m_busy[p] = 0; m_iv[p] = 0; end
      end else begin
        for (int p = 0; p < PN; p++) begin
          m_iv[p] = m_busy[p];
          if (m_busy[p]) begin
            m_iown[p]  = m_own[p];
            m_iaddr[p] = m_addr[p];
            m_ilast[p] = (m_left[p] == 1);
            m_left[p]  = m_left[p] - 1;
            m_addr[p]  = (m_addr[p] + 1) % DEPTH;
            if (m_left[p] == 0) m_busy[p] = 0;
          end
        end
        for (int p = 0; p < PN; p++) begin
          if (gown[p] >= 0) begin
            m_busy[p] = 1;
            m_own[p]  = gown[p];
            m_addr[p] = int'(req_addr_i[gown[p]*AW +: AW]);
            m_left[p] = int'(req_len_i[gown[p]*LW +: LW]) + 1;
          end
        end
        if (any_g) m_rr = (last_g + 1) % RN;
      end
    end
  end

  typedef struct {
    int req; int addr; int len;
    int exp_wait; int exp_beats; int exp_last_addr;
  } vec_t;

  vec_t vecs [5];
  logic [RN-1:0] cont_exp [5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin : main
    logic [RN-1:0] pend;
    logic [DW-1:0] last_d;
    int w, beats, n;
    bit got, done;

    for (int i = 0; i < DEPTH; i++) rf_mem[i] = $urandom;
    vecs[0] = '{req: 0, addr: 5,  len: 2,  exp_wait: 0, exp_beats: 3,  exp_last_addr: 7};
    vecs[1] = '{req: 1, addr: 30, len: 3,  exp_wait: 0, exp_beats: 4,  exp_last_addr: 1};
    vecs[2] = '{req: 2, addr: 31, len: 0,  exp_wait: 0, exp_beats: 1,  exp_last_addr: 31};
    vecs[3] = '{req: 3, addr: 0,  len: 15, exp_wait: 0, exp_beats: 16, exp_last_addr: 15};
    vecs[4] = '{req: 0, addr: 20, len: 15, exp_wait: 0, exp_beats: 16, exp_last_addr: 3};
    cont_exp = '{4'b0011, 4'b0000, 4'b1100, 4'b0000, 4'b0001};

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset_state_busy", 128'(busy_o), 128'(0));
    chk("reset_state_addr", 128'(rf_read_addr_o), 128'(0));

    // Contention: four len=0 requests on two ports, req0 re-raised right away.
    cyc();
    for (int r = 0; r < RN; r++) set_req(r, r*4, 0);
    pend = '1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("cont_ready", 128'(req_ready_o), 128'(cont_exp[i]));
      if (i == 1) chk("cont_ports01", 128'(rf_read_addr_o), 128'({5'd4, 5'd0}));
      if (i == 3) chk("cont_ports23", 128'(rf_read_addr_o), 128'({5'd12, 5'd8}));
      cyc();
      pend = pend & ~cont_exp[i];
      if (i == 0) pend[0] = 1'b1;
      req_valid_i = pend;
    end
    repeat (3) cyc();

    // Back-to-back on one requester: one bubble between bursts.
    set_req(0, 12, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      chk("b2b_ready", 128'(req_ready_o[0]), 128'(i % 2 == 0));
      cyc();
    end
    req_valid_i = '0;
    repeat (3) cyc();

    // Table of single bursts from idle.
    foreach (vecs[i]) begin
      set_req(vecs[i].req, vecs[i].addr, vecs[i].len);
      w = 0; got = 0;
      while (!got && w < 20) begin
        @(negedge clk_i);
        if (req_ready_o[vecs[i].req]) got = 1; else w++;
      end
      chk("tbl_wait", 128'(w), 128'(vecs[i].exp_wait));
      cyc();
      req_valid_i = '0;
      beats = 0; done = 0; n = 0; last_d = '0;
      while (!done && n < 40) begin
        @(negedge clk_i);
        n++;
        if (rsp_valid_o[vecs[i].req]) begin
          beats++;
          if (rsp_last_o[vecs[i].req]) begin
            done = 1;
            last_d = rsp_data_o[vecs[i].req*DW +: DW];
          end
        end
      end
      chk("tbl_beats", 128'(beats), 128'(vecs[i].exp_beats));
      chk("tbl_last_data", 128'(last_d), 128'(rf_mem[vecs[i].exp_last_addr]));
      repeat (2) cyc();
    end

    // Flush mid-burst, then a request accepted right after.
    set_req(0, 0, 7);
    @(negedge clk_i);
    chk("flush_grant", 128'(req_ready_o[0]), 128'(1));
    cyc(); req_valid_i = '0;
    cyc(); cyc();
    @(negedge clk_i);
    chk("flush_third_addr", 128'(rf_read_addr_o), 128'(2));
    cyc(); flush_i = 1'b1;
    @(negedge clk_i);
    chk("flush_ready_blocked", 128'(req_ready_o), 128'(0));
    cyc(); flush_i = 1'b0;
    set_req(1, 9, 1);
    @(negedge clk_i);
    chk("flush_addr_idle", 128'(rf_read_addr_o), 128'(0));
    chk("flush_no_rsp", 128'(rsp_valid_o), 128'(0));
    chk("flush_busy", 128'(busy_o), 128'(0));
    chk("flush_new_grant", 128'(req_ready_o), 128'(4'b0010));
    cyc(); req_valid_i = '0;
    repeat (5) cyc();

    // Asynchronous reset between edges mid-burst.
    set_req(2, 10, 9);
    @(negedge clk_i);
    cyc(); req_valid_i = '0;
    cyc(); cyc();
    @(negedge clk_i);
    chk("arst_pre_busy", 128'(busy_o), 128'(1));
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("arst_addr", 128'(rf_read_addr_o), 128'(0));
    chk("arst_rsp_valid", 128'(rsp_valid_o), 128'(0));
    chk("arst_rsp_data", 128'(rsp_data_o), 128'(0));
    chk("arst_busy", 128'(busy_o), 128'(0));
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("arst_quiet_rsp", 128'(rsp_valid_o), 128'(0));
      chk("arst_quiet_busy", 128'(busy_o), 128'(0));
    end

    // Random traffic; the model checks every cycle and drives the handshake.
    for (int c = 0; c < 800; c++) begin
      cyc();
      for (int r = 0; r < RN; r++) begin
        if (req_valid_i[r] && exp_ready[r]) req_valid_i[r] = 1'b0;
        if (!req_valid_i[r] && $urandom_range(0, 2) == 0)
          set_req(r, int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 15)));
      end
      flush_i = ($urandom_range(0, 39) == 0);
    end
    cyc();
    req_valid_i = '0;
    flush_i = 1'b0;
    repeat (25) cyc();
    @(negedge clk_i);
    chk("final_idle", 128'(busy_o), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
